// File: rtl/adaptive_loop_filter.sv
// adaptive_loop_filter: random-walk PLL loop filter with a fast modulus-2**k counter and adaptive k.
// Define ALF_ADAPT_EN to build the slow stage, quiet timer, k adaptation and lock flag.
module adaptive_loop_filter #(
    parameter int MOD_LOG2_MIN  = 2,
    parameter int MOD_LOG2_MAX  = 6,
    parameter int MOD_LOG2_INIT = 4,
    parameter int M_LOG2        = 6,
    parameter int LOCK_CYCLES   = 128,
    parameter int KW            = $clog2(MOD_LOG2_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          forwarding_i,
    input  logic          slowing_i,
    input  logic          freeze_i,
    output logic          positiveShift_o,
    output logic          negativeShift_o,
    output logic [KW-1:0] modLog2_o,
    output logic          locked_o
);
    localparam int NW = MOD_LOG2_MAX + 2;

    if (MOD_LOG2_MIN > MOD_LOG2_INIT || MOD_LOG2_INIT > MOD_LOG2_MAX || M_LOG2 < 1 || LOCK_CYCLES < 2) begin : g_bad_params
        $error("adaptive_loop_filter: inconsistent parameters");
    end

    logic signed [1:0]    step;
    logic signed [NW-1:0] n_q, n_d, n_next, n_lim;
    logic [KW-1:0]        k;
    logic                 pos_q, neg_q, fast_pos, fast_neg, trig, ovf, expire;

    always_comb begin
        step     = freeze_i ? 2'sd0 : (forwarding_i & ~slowing_i) ? 2'sd1 : (slowing_i & ~forwarding_i) ? -2'sd1 : 2'sd0;
        n_next   = n_q + {{(NW-2){step[1]}}, step};
        n_lim    = NW'(1) << k;
        fast_pos = n_next == n_lim;
        fast_neg = n_next == -n_lim;
        trig     = fast_pos | fast_neg;
    end

    // Every k change also clears the fast counter so it always stays inside the new modulus.
    assign n_d = (ovf | trig | expire) ? '0 : n_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            n_q   <= '0;
            pos_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            pos_q <= fast_pos;
            neg_q <= fast_neg;
        end
    end

    assign positiveShift_o = pos_q;
    assign negativeShift_o = neg_q;
    assign modLog2_o       = k;

`ifdef ALF_ADAPT_EN
    localparam int MW = M_LOG2 + 2;
    localparam int QW = $clog2(LOCK_CYCLES);
    localparam logic signed [MW-1:0] M_LIM = MW'(1 << M_LOG2);

    logic signed [MW-1:0] m_q, m_d, m_next;
    logic [QW-1:0]        q_q, q_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 lock_q, lock_d;

    always_comb begin
        m_next = m_q + {{(MW-2){step[1]}}, step};
        ovf    = (m_next == M_LIM) || (m_next == -M_LIM);
        expire = !freeze_i && !trig && !ovf && (q_q == QW'(LOCK_CYCLES - 1));
        m_d    = ovf ? '0 : m_next;
        q_d    = freeze_i ? q_q : (ovf || trig || expire) ? '0 : q_q + 1'b1;
        k_d    = ovf ? ((k_q > KW'(MOD_LOG2_MIN)) ? k_q - 1'b1 : k_q)
               : expire ? ((k_q < KW'(MOD_LOG2_MAX)) ? k_q + 1'b1 : k_q) : k_q;
        lock_d = ovf ? 1'b0 : expire ? 1'b1 : lock_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_q    <= '0;
            q_q    <= '0;
            k_q    <= KW'(MOD_LOG2_INIT);
            lock_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            q_q    <= q_d;
            k_q    <= k_d;
            lock_q <= lock_d;
        end
    end

    assign k        = k_q;
    assign locked_o = lock_q;
`else
    assign k        = KW'(MOD_LOG2_INIT);
    assign ovf      = 1'b0;
    assign expire   = 1'b0;
    assign locked_o = 1'b0;
`endif
endmodule

// File: tb/tb_adaptive_loop_filter.sv
// tb_adaptive_loop_filter: directed checks of the fast stage, adaptation, freeze and reset behaviour.
module tb_adaptive_loop_filter;
`ifdef ALF_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    logic       clk_i, reset_i, forwarding_i, slowing_i, freeze_i;
    logic       positiveShift_o, negativeShift_o, locked_o;
    logic [2:0] modLog2_o;
    int         checks, errors;

    adaptive_loop_filter dut (
        .clk_i(clk_i), .reset_i(reset_i), .forwarding_i(forwarding_i), .slowing_i(slowing_i),
        .freeze_i(freeze_i), .positiveShift_o(positiveShift_o), .negativeShift_o(negativeShift_o),
        .modLog2_o(modLog2_o), .locked_o(locked_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; forwarding_i = 1'b0; slowing_i = 1'b0; freeze_i = 1'b0;
        cyc(1);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        forwarding_i = 1'b1;
        cyc(7);
        do_reset();
        checks += 4;
        if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL reset_pos got %b exp 0", positiveShift_o); end
        if (negativeShift_o !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", negativeShift_o); end
        if (modLog2_o !== 3'd4) begin errors++; $display("FAIL reset_k got %0d exp 4", modLog2_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", locked_o); end
    endtask

    task automatic test_fast();
        do_reset();
        forwarding_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            checks += 2;
            if (positiveShift_o !== (i == 16)) begin errors++; $display("FAIL fast16_pos[%0d] got %b exp %b", i, positiveShift_o, i == 16); end
            if (negativeShift_o !== 1'b0) begin errors++; $display("FAIL fast16_neg[%0d] got %b exp 0", i, negativeShift_o); end
        end
        forwarding_i = 1'b0;
        cyc(1);
        checks++;
        if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL fast16_once got %b exp 0", positiveShift_o); end
        do_reset();
        forwarding_i = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            checks++;
            if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL fast15_pos[%0d] got %b exp 0", i, positiveShift_o); end
        end
        forwarding_i = 1'b0;
        cyc(2);
        checks++;
        if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL fast15_tail got %b exp 0", positiveShift_o); end
    endtask

    task automatic test_both();
        do_reset();
        forwarding_i = 1'b1; slowing_i = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            cyc(1);
            checks += 3;
            if ((positiveShift_o | negativeShift_o) !== 1'b0) begin errors++; $display("FAIL both_pulse[%0d] got %b%b exp 00", i, positiveShift_o, negativeShift_o); end
            if (locked_o !== (ADAPT && i == 128)) begin errors++; $display("FAIL both_lock[%0d] got %b exp %b", i, locked_o, ADAPT && i == 128); end
            if (modLog2_o !== ((ADAPT && i == 128) ? 3'd5 : 3'd4)) begin errors++; $display("FAIL both_k[%0d] got %0d", i, modLog2_o); end
        end
        forwarding_i = 1'b0; slowing_i = 1'b0;
    endtask

    task automatic test_slow();
        logic [2:0] ek;
        do_reset();
        slowing_i = 1'b1;
        for (int i = 1; i <= 72; i++) begin
            cyc(1);
            ek = (ADAPT && i >= 64) ? 3'd3 : 3'd4;
            checks += 3;
            if (negativeShift_o !== ((i <= 64) ? (i % 16 == 0) : (ADAPT && i == 72))) begin errors++; $display("FAIL slow_neg[%0d] got %b", i, negativeShift_o); end
            if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL slow_pos[%0d] got %b exp 0", i, positiveShift_o); end
            if (modLog2_o !== ek) begin errors++; $display("FAIL slow_k[%0d] got %0d exp %0d", i, modLog2_o, ek); end
        end
        slowing_i = 1'b0;
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL slow_lock got %b exp 0", locked_o); end
    endtask

    task automatic test_idle();
        do_reset();
        cyc(127);
        checks += 2;
        if (modLog2_o !== 3'd4) begin errors++; $display("FAIL idle127_k got %0d exp 4", modLog2_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL idle127_lock got %b exp 0", locked_o); end
        cyc(1);
        checks += 2;
        if (modLog2_o !== (ADAPT ? 3'd5 : 3'd4)) begin errors++; $display("FAIL idle128_k got %0d", modLog2_o); end
        if (locked_o !== ADAPT) begin errors++; $display("FAIL idle128_lock got %b exp %b", locked_o, ADAPT); end
        cyc(128);
        checks++;
        if (modLog2_o !== (ADAPT ? 3'd6 : 3'd4)) begin errors++; $display("FAIL idle256_k got %0d", modLog2_o); end
        cyc(128);
        checks += 2;
        if (modLog2_o !== (ADAPT ? 3'd6 : 3'd4)) begin errors++; $display("FAIL idle_sat_k got %0d", modLog2_o); end
        if (locked_o !== ADAPT) begin errors++; $display("FAIL idle_sat_lock got %b exp %b", locked_o, ADAPT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        forwarding_i = 1'b1;
        cyc(10);
        reset_i = 1'b1; forwarding_i = 1'b0;
        cyc(1);
        reset_i = 1'b0;
        checks += 2;
        if (positiveShift_o !== 1'b0) begin errors++; $display("FAIL midrst_pos got %b exp 0", positiveShift_o); end
        if (modLog2_o !== 3'd4) begin errors++; $display("FAIL midrst_k got %0d exp 4", modLog2_o); end
        forwarding_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            checks++;
            if (positiveShift_o !== (i == 16)) begin errors++; $display("FAIL midrst_pos[%0d] got %b exp %b", i, positiveShift_o, i == 16); end
        end
        forwarding_i = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        forwarding_i = 1'b1;
        cyc(5);
        freeze_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            checks++;
            if ((positiveShift_o | negativeShift_o) !== 1'b0) begin errors++; $display("FAIL frz_pulse[%0d] got %b%b exp 00", i, positiveShift_o, negativeShift_o); end
        end
        checks += 2;
        if (modLog2_o !== 3'd4) begin errors++; $display("FAIL frz_k got %0d exp 4", modLog2_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL frz_lock got %b exp 0", locked_o); end
        freeze_i = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            cyc(1);
            checks++;
            if (positiveShift_o !== (i == 11)) begin errors++; $display("FAIL frz_resume[%0d] got %b exp %b", i, positiveShift_o, i == 11); end
        end
        forwarding_i = 1'b0;
        do_reset();
        cyc(100);
        freeze_i = 1'b1;
        cyc(50);
        freeze_i = 1'b0;
        cyc(27);
        checks += 2;
        if (modLog2_o !== 3'd4) begin errors++; $display("FAIL frzq_k got %0d exp 4", modLog2_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL frzq_lock got %b exp 0", locked_o); end
        cyc(1);
        checks += 2;
        if (modLog2_o !== (ADAPT ? 3'd5 : 3'd4)) begin errors++; $display("FAIL frzq_exp_k got %0d", modLog2_o); end
        if (locked_o !== ADAPT) begin errors++; $display("FAIL frzq_exp_lock got %b exp %b", locked_o, ADAPT); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_i = 1'b1; forwarding_i = 1'b0; slowing_i = 1'b0; freeze_i = 1'b0;
        test_reset();
        test_fast();
        test_both();
        test_slow();
        test_idle();
        test_reset_mid();
        test_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
